// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the pulse handshake source: channel FSM encoding,
// parameter limits and a small clamping helper.
package pulse_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } hs_state_t;

    localparam int SYNC_STEP_MIN = 2;
    localparam int SYNC_STEP_MAX = 4;
    localparam int CNT_W_MIN     = 1;
    localparam int CNT_W_MAX     = 8;

    // Force a parameter into its legal range.
    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pulse_multi_handshake_src_if.sv
// Four-phase request/acknowledge bundle between the source engine (master)
// and the destination domain (slave), one bit per channel.
interface pulse_multi_handshake_src_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/jlsemi_util_sync_pos_with_rst_low.sv
// Multi-flop level synchroniser, posedge clocked, cleared by active-low reset.
module jlsemi_util_sync_pos_with_rst_low #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg <= '0;
        else        sync_reg <= {sync_reg[STAGES-2:0], d};
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/pulse_hs_src_ch.sv
// One handshake channel: IDLE/REQ/WAIT FSM, pending-event counter and
// sticky overflow flag. The counter exists only when PULSE_HS_QUEUE_EN is
// defined; otherwise a pulse during a handshake is dropped and flagged.
module pulse_hs_src_ch
    import pulse_hs_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_pulse,
    input  logic             ack_s,
    input  logic             ovf_clr,
    output logic             req,
    output logic             busy,
    output logic             done_pulse,
    output logic             ovf,
    output logic [CNT_W-1:0] pend_cnt
);
    hs_state_t state_reg, state_next;
    logic      held_pulse;      // pulse arriving while a handshake is in flight
    logic      completion;      // WAIT with ack_s low: handshake finishes now
    logic      queue_nonempty;
    logic      queue_next_nonempty;
    logic      ovf_set;
    logic      req_reg, busy_reg, done_reg, ovf_reg;

    // Next-state decode; relaunch if events are queued or one arrives now.
    always_comb begin
        state_next = state_reg;
        held_pulse = 1'b0;
        completion = 1'b0;
        case (state_reg)
            IDLE: if (src_pulse) state_next = REQ;
            REQ: begin
                held_pulse = src_pulse;
                if (ack_s) state_next = WAIT;
            end
            WAIT: begin
                if (ack_s) begin
                    held_pulse = src_pulse;
                end else begin
                    completion = 1'b1;
                    state_next = (queue_nonempty || src_pulse) ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; a stale ack in IDLE has no effect since IDLE ignores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

`ifdef PULSE_HS_QUEUE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Queue bookkeeping: count held pulses, pop one on relaunch, saturate.
    always_comb begin
        cnt_next = cnt_reg;
        ovf_set  = 1'b0;
        if (completion && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CNT_W'(1) + CNT_W'(src_pulse);
        end else if (held_pulse) begin
            if (cnt_reg == CNT_MAX) ovf_set  = 1'b1;
            else                    cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Pending counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
    end

    assign queue_nonempty      = (cnt_reg != '0);
    assign queue_next_nonempty = (cnt_next != '0);
    assign pend_cnt            = cnt_reg;
`else
    assign ovf_set             = held_pulse;
    assign queue_nonempty      = 1'b0;
    assign queue_next_nonempty = 1'b0;
    assign pend_cnt            = '0;
`endif

    // Registered outputs, computed from next-state so req follows a pulse by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_reg  <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            req_reg  <= (state_next == REQ);
            busy_reg <= (state_next != IDLE) || queue_next_nonempty;
            done_reg <= completion;
            ovf_reg  <= ovf_set || (ovf_reg && !ovf_clr);
        end
    end

    assign req        = req_reg;
    assign busy       = busy_reg;
    assign done_pulse = done_reg;
    assign ovf        = ovf_reg;
endmodule

// File: rtl/pulse_multi_handshake_src.sv
// Multi-channel four-phase pulse handshake source. Each channel has its own
// ack synchroniser and handshake engine. Optional event queue: PULSE_HS_QUEUE_EN.
module pulse_multi_handshake_src
    import pulse_hs_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SYNC_STEP = 2,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       src_pulse,
    pulse_multi_handshake_src_if.master hs,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done_pulse,
    output logic [NUM_CH*CNT_W-1:0] pend_cnt,
    output logic [NUM_CH-1:0]       ovf,
    input  logic [NUM_CH-1:0]       ovf_clr
);
    localparam int SYNC_N = clamp_int(SYNC_STEP, SYNC_STEP_MIN, SYNC_STEP_MAX);

    logic [NUM_CH-1:0] ack_s;
    logic [NUM_CH-1:0] req_w;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            jlsemi_util_sync_pos_with_rst_low #(.STAGES(SYNC_N)) u_ack_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (hs.ack[gi]),
                .q     (ack_s[gi])
            );

            pulse_hs_src_ch #(.CNT_W(CNT_W)) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .src_pulse  (src_pulse[gi]),
                .ack_s      (ack_s[gi]),
                .ovf_clr    (ovf_clr[gi]),
                .req        (req_w[gi]),
                .busy       (busy[gi]),
                .done_pulse (done_pulse[gi]),
                .ovf        (ovf[gi]),
                .pend_cnt   (pend_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign hs.req = req_w;
endmodule

// File: tb/tb_pulse_multi_handshake_src.sv
// Directed bench for pulse_multi_handshake_src (NUM_CH=4, SYNC_STEP=2, CNT_W=4).
// The destination model echoes req as ack through 3 flops, with a per-channel
// override to hold ack at a fixed level.
module tb_pulse_multi_handshake_src;
`ifdef PULSE_HS_QUEUE_EN
    localparam bit Q = 1'b1;
`else
    localparam bit Q = 1'b0;
`endif
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] src_pulse = '0;
    logic [NCH-1:0] ovf_clr = '0;
    logic [NCH-1:0] busy, done_pulse, ovf;
    logic [NCH*4-1:0] pend_cnt;

    logic [NCH-1:0] hold_en = '0;
    logic [NCH-1:0] hold_val = '0;
    logic [2:0]     dly [NCH];
    logic [NCH-1:0] ack_model;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt [NCH] = '{default: 0};
    int snap [NCH];

    pulse_multi_handshake_src_if #(.NUM_CH(NCH)) hs ();

    pulse_multi_handshake_src #(.NUM_CH(NCH), .SYNC_STEP(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_pulse  (src_pulse),
        .hs         (hs),
        .busy       (busy),
        .done_pulse (done_pulse),
        .pend_cnt   (pend_cnt),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    // Destination model: 3-cycle echo of req, reset together with the DUT.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) dly[i] <= 3'b000;
            else        dly[i] <= {dly[i][1:0], hs.req[i]};
        end
    end

    always_comb begin
        ack_model = '0;
        for (int i = 0; i < NCH; i++)
            ack_model[i] = hold_en[i] ? hold_val[i] : dly[i][2];
    end
    assign hs.ack = ack_model;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++)
            if (done_pulse[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] pend(input int ch);
        return pend_cnt[ch*4 +: 4];
    endfunction

    task automatic wait_idle(input string tag, input logic [NCH-1:0] mask, input int limit);
        int k = 0;
        while (((busy & mask) != '0) && (k < limit)) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(busy & mask), 32'd0);
        tick(2);
    endtask

    task automatic take_snap();
        for (int i = 0; i < NCH; i++) snap[i] = done_cnt[i];
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_req",   32'(hs.req),     32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done_pulse), 32'd0);
        chk("rst_pend",  32'(pend_cnt),   32'd0);
        chk("rst_ovf",   32'(ovf),        32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single event on ch0
        take_snap();
        src_pulse[0] = 1'b1;
        tick(1);
        src_pulse[0] = 1'b0;
        chk("single_req_c1",  32'(hs.req[0]), 32'd1);
        chk("single_busy_c1", 32'(busy[0]),   32'd1);
        wait_idle("single_idle", 4'b0001, 200);
        chk("single_done_n",  32'(done_cnt[0] - snap[0]), 32'd1);
        chk("single_pend",    32'(pend(0)), 32'd0);

        // Burst on ch1: 5 pulses while in REQ
        take_snap();
        src_pulse[1] = 1'b1;
        tick(1);
        tick(5);
        src_pulse[1] = 1'b0;
        chk("burst_pend5",  32'(pend(1)), Q ? 32'd5 : 32'd0);
        chk("burst_ovf",    32'(ovf[1]),  Q ? 32'd0 : 32'd1);
        wait_idle("burst_idle", 4'b0010, 500);
        chk("burst_done_n", 32'(done_cnt[1] - snap[1]), Q ? 32'd6 : 32'd1);
        ovf_clr[1] = 1'b1;
        tick(1);
        ovf_clr[1] = 1'b0;
        chk("burst_ovf_clr", 32'(ovf[1]), 32'd0);

        // Saturation on ch2: ack held low, 17 pulses during REQ
        take_snap();
        hold_en[2] = 1'b1;
        hold_val[2] = 1'b0;
        src_pulse[2] = 1'b1;
        tick(1);
        tick(17);
        chk("sat_pend",  32'(pend(2)), Q ? 32'd15 : 32'd0);
        chk("sat_ovf",   32'(ovf[2]),  32'd1);
        ovf_clr[2] = 1'b1;
        tick(1);
        src_pulse[2] = 1'b0;
        chk("sat_set_wins", 32'(ovf[2]), 32'd1);
        tick(1);
        ovf_clr[2] = 1'b0;
        chk("sat_clr_alone", 32'(ovf[2]), 32'd0);
        chk("sat_pend_hold", 32'(pend(2)), Q ? 32'd15 : 32'd0);
        hold_en[2] = 1'b0;
        wait_idle("sat_idle", 4'b0100, 2000);
        chk("sat_done_n", 32'(done_cnt[2] - snap[2]), Q ? 32'd16 : 32'd1);

        // Pulse landing exactly on the completion cycle of ch3
        take_snap();
        src_pulse[3] = 1'b1;
        tick(1);
        src_pulse[3] = 1'b0;
        tick(11);
        chk("cc_req_wait",  32'(hs.req[3]),     32'd0);
        chk("cc_done_pre",  32'(done_pulse[3]), 32'd0);
        src_pulse[3] = 1'b1;
        tick(1);
        src_pulse[3] = 1'b0;
        chk("cc_done",      32'(done_pulse[3]), 32'd1);
        chk("cc_req_again", 32'(hs.req[3]),     32'd1);
        chk("cc_pend",      32'(pend(3)),       32'd0);
        chk("cc_ovf",       32'(ovf[3]),        32'd0);
        wait_idle("cc_idle", 4'b1000, 200);
        chk("cc_done_n", 32'(done_cnt[3] - snap[3]), 32'd2);

        // Reset in the middle of a handshake on ch0
        src_pulse[0] = 1'b1;
        tick(1);
        tick(3);
        src_pulse[0] = 1'b0;
        chk("mid_req",  32'(hs.req[0]), 32'd1);
        chk("mid_pend", 32'(pend(0)),   Q ? 32'd3 : 32'd0);
        hold_en[0] = 1'b1;
        hold_val[0] = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_req",  32'(hs.req),     32'd0);
        chk("mid_rst_busy", 32'(busy),       32'd0);
        chk("mid_rst_done", 32'(done_pulse), 32'd0);
        chk("mid_rst_pend", 32'(pend_cnt),   32'd0);
        chk("mid_rst_ovf",  32'(ovf),        32'd0);
        tick(2);
        rst_n = 1'b1;
        take_snap();
        tick(10);
        chk("stale_req",    32'(hs.req[0]), 32'd0);
        chk("stale_busy",   32'(busy[0]),   32'd0);
        chk("stale_done_n", 32'(done_cnt[0] - snap[0]), 32'd0);
        hold_en[0] = 1'b0;
        hold_val[0] = 1'b0;
        tick(6);

        // All channels concurrently
        take_snap();
        src_pulse = 4'hF;
        tick(1);
        src_pulse = 4'h0;
        chk("all_req", 32'(hs.req), 32'hF);
        wait_idle("all_idle", 4'hF, 300);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("all_done_n_ch%0d", i), 32'(done_cnt[i] - snap[i]), 32'd1);
        chk("all_ovf",  32'(ovf),      32'd0);
        chk("all_pend", 32'(pend_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pulse_multi_handshake_src.md
# pulse_multi_handshake_src

Source-side engine for a multi-channel, four-phase pulse handshake toward an asynchronous destination domain. Each of NUM_CH channels turns single-cycle event pulses into a held request level. The channel then waits for the far side's acknowledge, synchronised into `clk`, before releasing the request. Pulses that arrive while a handshake is in flight are queued in a per-channel saturating counter and replayed back-to-back, so no event is lost below the counter limit. The block sits in the fast domain ahead of the existing destination-side pulse synchronisers.

## Interface
- `NUM_CH`, 4: number of independent channels (1..32)
- `SYNC_STEP`, 2: flop stages on each `ack` synchroniser (2..4)
- `CNT_W`, 4: width of the per-channel pending counter (1..8); only meaningful with the queue feature compiled in
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `src_pulse`  in  NUM_CH  single-cycle event per channel
- `req`  out  NUM_CH  request level, registered, driven to the destination domain
- `ack`  in  NUM_CH  acknowledge from the destination domain, asynchronous to `clk`
- `busy`  out  NUM_CH  channel is in a handshake or has pending events
- `done_pulse`  out  NUM_CH  one-cycle pulse when a handshake completes
- `pend_cnt`  out  NUM_CH*CNT_W  queued events; channel i occupies bits [i*CNT_W +: CNT_W]
- `ovf`  out  NUM_CH  sticky flag: an event was dropped
- `ovf_clr`  in  NUM_CH  clears `ovf`

## Operation
- Channels are fully independent. `ack[i]` passes through a SYNC_STEP synchroniser to give `ack_s[i]`.
- Each channel has a 3-state FSM:
  - **IDLE:** `req`=0. On `src_pulse`, go to REQ.
  - **REQ:** `req`=1. When `ack_s`=1, go to WAIT.
  - **WAIT:** `req`=0. When `ack_s`=0, the handshake is complete and `done_pulse` fires. Then:
    - if `pend_cnt`>0 or `src_pulse` is asserted this cycle, go to REQ;
    - otherwise go to IDLE.
- Pending counter:
  - A `src_pulse` arriving in REQ, or in WAIT before completion, increments `pend_cnt`.
  - On the completion cycle, `pend_cnt` updates by +`src_pulse` −1 when relaunching from the queue. A pulse arriving on that cycle with an empty queue launches directly.
  - Saturates at 2^CNT_W−1. A further pulse is dropped and sets `ovf`.
- `ovf`: when a set and `ovf_clr` occur in the same cycle, set wins.
- `busy` = (state≠IDLE) | (`pend_cnt`≠0).
- Reset values: `req`=0, `busy`=0, `done_pulse`=0, `pend_cnt`=0, `ovf`=0, all FSMs in IDLE, synchronisers cleared.
- Reset asserted mid-handshake abandons the handshake and clears the queue.
  - The destination side must be reset together with this block.
  - If it is not, a stale `ack_s`=1 after reset is ignored while the FSM is in IDLE.

## Timing
- `src_pulse` in IDLE at cycle 0 → `req`=1 at cycle 1.
- `ack` rising → `ack_s`=1 after SYNC_STEP edges → `req`=0 on the following edge.
- `ack` falling → `ack_s`=0 after SYNC_STEP edges → `done_pulse` on the following edge. `req` reasserts on that same edge if relaunching.
- Minimum per-event period is 2·(SYNC_STEP+1) cycles plus the destination round trip.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PULSE_HS_QUEUE_EN` defined: the pending counter is built as described above.
- Not defined:
  - no counter is built and `pend_cnt` is tied to 0;
  - any `src_pulse` in REQ, or in WAIT before completion, is dropped and sets `ovf`;
  - a pulse on the completion cycle still launches.

## Structure
- Shared package `pulse_hs_pkg` holds:
  - FSM encodings: IDLE=2'b00, REQ=2'b01, WAIT=2'b10;
  - limits on SYNC_STEP and CNT_W.
- Sub-module `pulse_hs_src_ch`: one channel (FSM, counter, `ovf`), instantiated NUM_CH times in a generate loop.
- Each `ack` synchroniser reuses `jlsemi_util_sync_pos_with_rst_low`.

## Test plan
- **Single event:** pulse on ch0; destination model echoes `req` as `ack` with 3-cycle delay → `req` high at cycle 1, exactly one `done_pulse`, `busy` back to 0, `pend_cnt`=0.
- **Burst:** 5 pulses on ch1 while in REQ, CNT_W=4 → `pend_cnt` reaches 5; 6 handshakes total; 6 `done_pulse`s; `ovf`=0.
- **Saturation:** 17 pulses during one handshake with CNT_W=4 → `pend_cnt`=15, `ovf`=1.
  - `ovf_clr` in the same cycle as an 18th pulse → `ovf` stays 1.
  - Next `ovf_clr` alone → `ovf`=0.
- **Completion-cycle pulse:** pulse lands exactly on the WAIT completion cycle with empty queue → direct relaunch; `pend_cnt` stays 0; `req` high next cycle.
- **Reset mid-handshake:** `rst_n` low while in REQ with `pend_cnt`=3 → all outputs 0 immediately (async).
  - Hold `ack`=1 after release → FSM stays IDLE with no `done_pulse`.
- **Queue compiled out:** without `PULSE_HS_QUEUE_EN`, 2 pulses during REQ → `ovf`=1, one `done_pulse` only; all NUM_CH channels run concurrently with no cross-talk.
